// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, IF/ID register, jump-target LUT and halt detection.
// Valid qualifies mach_code on every cycle; there is no back-pressure other than Stall.
module fetch_unit #(
  parameter int                  PC_W      = 10,
  parameter int                  INSTR_W   = 9,
  parameter logic [INSTR_W-1:0]  HALT_CODE = 9'h1FF,
  parameter int                  CNT_W     = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Stall,
  input  logic               Jump,
  input  logic [7:0]         Jptr,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               lut_we,
  input  logic [7:0]         lut_addr,
  input  logic [PC_W-1:0]    lut_wdata,
  output logic [INSTR_W-1:0] mach_code,
  output logic               Valid,
  output logic               Done,
  output logic [CNT_W-1:0]   InstCnt,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   mc_q, mc_d;
  logic                 valid_q, valid_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 start_q;
  logic                 start_rise;
  logic [PC_W-1:0]      lut_q [0:255];

  assign start_rise = Start & ~start_q;

  // LUT contents survive reset and may only change while the core is idle.
  always_ff @(posedge Clk) begin
    if (lut_we && (state_q == S_IDLE)) begin
      lut_q[lut_addr] <= lut_wdata;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      mc_q    <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mc_q    <= mc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      start_q <= Start;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mc_d    = mc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        mc_d    = '0;
        if (start_rise) begin
          state_d = S_RUN;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        // A redirect wins over both stall and halt: the word at the old PC is wrong-path.
        if (Jump) begin
          pc_d    = lut_q[Jptr];
          mc_d    = '0;
          valid_d = 1'b0;
        end else if (!Stall) begin
          if (imem_data == HALT_CODE) begin
            state_d = S_DONE;
            mc_d    = '0;
            valid_d = 1'b0;
          end else begin
            mc_d    = imem_data;
            valid_d = 1'b1;
            pc_d    = pc_q + 1'b1;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        valid_d = 1'b0;
        if (!Start) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign imem_addr   = pc_q;
  assign mach_code   = mc_q;
  assign Valid       = valid_q;
  assign Done        = (state_q == S_DONE);
  assign InstCnt     = cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table, directed corner sequences, and a randomized
// run compared against an architectural model of the fetch rules.
module tb_fetch_unit;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;
  localparam int CNT_W   = 16;
  localparam int HALT    = 9'h1FF;
  localparam int NPC     = 1 << PC_W;

  logic               Clk = 1'b0;
  logic               Reset = 1'b0;
  logic               Start = 1'b0;
  logic               Stall = 1'b0;
  logic               Jump = 1'b0;
  logic [7:0]         Jptr = '0;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               lut_we = 1'b0;
  logic [7:0]         lut_addr = '0;
  logic [PC_W-1:0]    lut_wdata = '0;
  logic [INSTR_W-1:0] mach_code;
  logic               Valid;
  logic               Done;
  logic [CNT_W-1:0]   InstCnt;
  logic [1:0]         dbg_state;

  logic [INSTR_W-1:0] rom [0:NPC-1];

  int errors = 0;
  int checks = 0;

  fetch_unit dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Jump(Jump), .Jptr(Jptr),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .lut_we(lut_we), .lut_addr(lut_addr), .lut_wdata(lut_wdata),
    .mach_code(mach_code), .Valid(Valid), .Done(Done), .InstCnt(InstCnt),
    .dbg_state_o(dbg_state)
  );

  assign imem_data = rom[imem_addr];

  always #5 Clk = ~Clk;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int pc, input int mc, input int v,
                         input int d, input int cnt);
    chk({tag, ".pc"},    32'(imem_addr), pc);
    chk({tag, ".mc"},    32'(mach_code), mc);
    chk({tag, ".valid"}, 32'(Valid),     v);
    chk({tag, ".done"},  32'(Done),      d);
    chk({tag, ".cnt"},   32'(InstCnt),   cnt);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < NPC; i++) rom[i] = '0;
  endtask

  task automatic do_reset(input string tag);
    Reset = 1'b0; Start = 1'b0; Stall = 1'b0; Jump = 1'b0; Jptr = '0;
    lut_we = 1'b0; lut_addr = '0; lut_wdata = '0;
    tick();
    chk_all(tag, 0, 0, 0, 0, 0);
    Reset = 1'b1;
  endtask

  task automatic load_lut(input int addr, input int val);
    lut_we = 1'b1; lut_addr = 8'(addr); lut_wdata = PC_W'(val);
    tick();
    lut_we = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       start;
    logic       stall;
    logic       jump;
    logic [7:0] jptr;
    int         pc;
    int         mc;
    int         v;
    int         d;
    int         cnt;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input bit s, input bit st, input bit j, input int p,
                              input int pc, input int mc, input int v, input int d,
                              input int cnt);
    vec_t r;
    r.start = s; r.stall = st; r.jump = j; r.jptr = 8'(p);
    r.pc = pc; r.mc = mc; r.v = v; r.d = d; r.cnt = cnt;
    return r;
  endfunction

  // ---------------- reference model ----------------
  int m_mode;   // 0 idle, 1 running, 2 halted
  int m_pc, m_mc, m_valid, m_cnt, m_prev;
  int lut_m [256];

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_mc = 0; m_valid = 0; m_cnt = 0; m_prev = 0;
  endtask

  task automatic model_step();
    int word;
    word = int'(rom[m_pc]);
    if (m_mode == 0) begin
      if (lut_we) lut_m[lut_addr] = int'(lut_wdata);
      m_valid = 0; m_mc = 0;
      if (Start && m_prev == 0) begin
        m_mode = 1; m_pc = 0; m_cnt = 0;
      end
    end else if (m_mode == 1) begin
      if (Jump) begin
        m_pc = lut_m[Jptr]; m_mc = 0; m_valid = 0;
      end else if (!Stall) begin
        if (word == HALT) begin
          m_mode = 2; m_mc = 0; m_valid = 0;
        end else begin
          m_mc = word; m_valid = 1;
          m_pc = (m_pc + 1) % NPC;
          m_cnt = (m_cnt == (1 << CNT_W) - 1) ? m_cnt : m_cnt + 1;
        end
      end
    end else begin
      m_valid = 0;
      if (!Start) m_mode = 0;
    end
    m_prev = Start ? 1 : 0;
  endtask

  task automatic rnd_cycle(input string tag);
    model_step();
    tick();
    chk_all(tag, m_pc, m_mc, m_valid, (m_mode == 2) ? 1 : 0, m_cnt);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    clear_rom();

    // Table: straight-line program, halt, restart, stall, stall+jump, jump on halt word.
    do_reset("rst0");
    rom[0] = 9'h011; rom[1] = 9'h022; rom[2] = 9'h033; rom[3] = 9'h1FF;
    rom[40] = 9'h0AA; rom[41] = 9'h1FF;
    load_lut(7, 40);
    load_lut(0, 2);
    tbl[0]  = mk(0, 0, 0, 0,  0, 0,     0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0,  0, 0,     0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0,  1, 'h011, 1, 0, 1);
    tbl[3]  = mk(1, 0, 0, 0,  2, 'h022, 1, 0, 2);
    tbl[4]  = mk(1, 0, 0, 0,  3, 'h033, 1, 0, 3);
    tbl[5]  = mk(1, 0, 0, 0,  3, 0,     0, 1, 3);
    tbl[6]  = mk(1, 0, 0, 0,  3, 0,     0, 1, 3);
    tbl[7]  = mk(0, 0, 0, 0,  3, 0,     0, 0, 3);
    tbl[8]  = mk(1, 0, 0, 0,  0, 0,     0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0,  1, 'h011, 1, 0, 1);
    tbl[10] = mk(0, 1, 0, 0,  1, 'h011, 1, 0, 1);
    tbl[11] = mk(0, 1, 1, 0,  2, 0,     0, 0, 1);
    tbl[12] = mk(0, 0, 0, 0,  3, 'h033, 1, 0, 2);
    tbl[13] = mk(0, 0, 1, 7, 40, 0,     0, 0, 2);
    tbl[14] = mk(0, 0, 0, 0, 41, 'h0AA, 1, 0, 3);
    tbl[15] = mk(0, 0, 0, 0, 41, 0,     0, 1, 3);
    for (int i = 0; i < 16; i++) begin
      Start = tbl[i].start; Stall = tbl[i].stall; Jump = tbl[i].jump; Jptr = tbl[i].jptr;
      tick();
      chk_all($sformatf("tbl%0d", i), tbl[i].pc, tbl[i].mc, tbl[i].v, tbl[i].d, tbl[i].cnt);
    end
    Start = 1'b0; Stall = 1'b0; Jump = 1'b0;

    // Jump after PC 1 issues; 3-cycle stall with LUT write attempts that must be ignored.
    do_reset("rst1");
    load_lut(7, 40);
    Start = 1'b1; tick(); chk_all("j.run", 0, 0, 0, 0, 0);
    Start = 1'b0; tick(); chk_all("j.f0", 1, 'h011, 1, 0, 1);
    tick();               chk_all("j.f1", 2, 'h022, 1, 0, 2);
    Stall = 1'b1; lut_we = 1'b1; lut_addr = 8'd7; lut_wdata = PC_W'(100);
    for (int i = 0; i < 3; i++) begin
      tick(); chk_all($sformatf("j.stall%0d", i), 2, 'h022, 1, 0, 2);
    end
    Stall = 1'b0; lut_we = 1'b0; Jump = 1'b1; Jptr = 8'd7;
    tick(); chk_all("j.redir", 40, 0, 0, 0, 2);
    Jump = 1'b0;
    tick(); chk_all("j.tgt", 41, 'h0AA, 1, 0, 3);
    tick(); chk_all("j.halt", 41, 0, 0, 1, 3);

    // PC wrap 1023 -> 0 entered via a jump taken from the start-up bubble.
    do_reset("rst2");
    clear_rom();
    rom[1022] = 9'h101; rom[1023] = 9'h102; rom[0] = 9'h011;
    for (int i = 1; i <= 4; i++) rom[i] = 9'(9'h020 + i);
    load_lut(9, 1022);
    Start = 1'b1; tick(); chk_all("w.run", 0, 0, 0, 0, 0);
    Start = 1'b0; Jump = 1'b1; Jptr = 8'd9;
    tick(); chk_all("w.redir", 1022, 0, 0, 0, 0);
    Jump = 1'b0;
    tick(); chk_all("w.f1022", 1023, 'h101, 1, 0, 1);
    tick(); chk_all("w.f1023", 0, 'h102, 1, 0, 2);
    tick(); chk_all("w.f0", 1, 'h011, 1, 0, 3);
    for (int i = 0; i < 4; i++) tick();
    chk_all("w.pc5", 5, 'h024, 1, 0, 7);

    // Asynchronous reset between edges while an instruction is valid.
    #2;
    Reset = 1'b0;
    #1;
    chk_all("arst", 0, 0, 0, 0, 0);
    chk("arst.state", 32'(dbg_state), 0);
    Reset = 1'b1;
    tick();

    // Randomized run against the model; every LUT entry is written first.
    do_reset("rst3");
    model_reset();
    for (int i = 0; i < NPC; i++) begin
      rom[i] = ($urandom_range(0, 15) == 0) ? 9'(HALT) : 9'($urandom_range(0, 510));
    end
    for (int i = 0; i < 256; i++) begin
      lut_we = 1'b1; lut_addr = 8'(i); lut_wdata = PC_W'($urandom_range(0, NPC - 1));
      rnd_cycle("lutload");
    end
    lut_we = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) Start = ~Start;
      Stall     = ($urandom_range(0, 3) == 0);
      Jump      = ($urandom_range(0, 7) == 0);
      Jptr      = 8'($urandom_range(0, 255));
      lut_we    = ($urandom_range(0, 3) == 0);
      lut_addr  = 8'($urandom_range(0, 255));
      lut_wdata = PC_W'($urandom_range(0, NPC - 1));
      rnd_cycle($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage feeding the control decoder.
- Holds the program counter, drives the instruction-memory address, and registers each fetched 9-bit machine word into an IF/ID register presented as mach_code.
- Resolves jumps through an internal jump-target lookup table indexed by the decoder's 8-bit Jptr. The table is loaded while the core is idle.
- Detects the halt word and signals program completion.

Parameters:
PC_W, 10, program counter / instruction address width
INSTR_W, 9, machine word width
HALT_CODE, 9'h1FF, machine word that terminates the program
CNT_W, 16, width of retired-instruction counter

Ports:
Clk  input  1  clock, all state updates on rising edge
Reset  input  1  asynchronous, active-low reset
Start  input  1  level; rising edge while IDLE begins execution at PC 0
Stall  input  1  hold PC and IF/ID register
Jump  input  1  taken-jump request from decode/execute for current mach_code
Jptr  input  8  LUT index for jump target
imem_addr  output  PC_W  instruction memory address (= PC, combinational)
imem_data  input  INSTR_W  instruction memory read data (asynchronous ROM)
lut_we  input  1  LUT write enable (honoured only in IDLE)
lut_addr  input  8  LUT write index
lut_wdata  input  PC_W  LUT write data
mach_code  output  INSTR_W  registered instruction to decoder
Valid  output  1  mach_code holds a real instruction
Done  output  1  program halted
InstCnt  output  CNT_W  count of instructions issued

Behaviour:
- Reset (Reset=0, asynchronous):
  - State=IDLE, PC=0, mach_code=0, Valid=0, Done=0, InstCnt=0.
  - LUT contents are not reset; all 256 entries are undefined until written.
- States: IDLE, RUN, DONE.
- IDLE:
  - Valid=0, Done=0.
  - lut_we=1 writes LUT[lut_addr] <= lut_wdata on the edge.
  - Start=1 with previous-cycle Start=0 -> RUN next cycle; PC=0, InstCnt cleared.
- RUN, per cycle, priority highest first:
  1. Jump=1:
     - PC <= LUT[Jptr].
     - mach_code <= 0, Valid <= 0 (flush the wrong-path word; 1-cycle bubble).
     - Overrides Stall and halt detection.
  2. Stall=1: PC, mach_code, Valid and InstCnt all hold.
  3. imem_data == HALT_CODE:
     - State <= DONE, Valid <= 0, mach_code <= 0, PC holds.
     - The halt word is never issued.
  4. Otherwise:
     - mach_code <= imem_data, Valid <= 1.
     - PC <= PC+1, wrapping modulo 2^PC_W (PC=2^PC_W-1 -> 0).
     - InstCnt <= InstCnt+1, saturating at all-ones.
- Jump received while Valid=0 is still honoured (redirect from bubble).
- lut_we is ignored outside IDLE.
- Latency:
  - Word at address A appears on mach_code the cycle after PC=A, absent stall.
  - Jump-to-first-valid-target latency is 2 edges: redirect edge, then fetch edge.
- DONE:
  - Done=1 (registered; asserts on the edge that enters DONE), Valid=0.
  - PC and InstCnt frozen.
  - Start=0 -> IDLE; Done clears on entry to IDLE.
  - Jump and Stall are ignored.
- IDLE/DONE: PC drives imem_addr unchanged. imem_data is ignored.
- Reset mid-RUN: immediate return to reset values. The in-flight instruction is discarded.
- Start held high continuously does not restart from DONE. A fresh rising edge in IDLE is required.

Test Plan:
- Reset/idle: Reset=0 mid-run with Valid=1, PC=5 -> immediately PC=0, Valid=0, Done=0, mach_code=0, InstCnt=0, state IDLE.
- Straight-line:
  - ROM[0..3]=9'h011,9'h022,9'h033,9'h1FF; pulse Start.
  - Required: mach_code 011,022,033 on successive cycles with Valid=1.
  - Then Valid=0, Done=1, InstCnt=3, PC held at 3.
- Jump:
  - LUT[7]=40 loaded in IDLE; ROM[40]=9'h0AA.
  - Jump=1, Jptr=7 while mach_code from PC 1 is valid.
  - Required: next cycle Valid=0, PC=40; following cycle mach_code=0AA, Valid=1.
- Stall and priority:
  - Stall=1 for 3 cycles -> mach_code, PC, InstCnt unchanged.
  - Stall=1 with Jump=1 -> jump taken, bubble inserted.
  - Jump in the cycle imem_data=HALT_CODE -> no DONE, redirect taken.
- Wrap and LUT gating:
  - PC_W=4, program filling addresses 14,15,0 -> PC wraps 15->0, fetch continues.
  - lut_we=1 during RUN -> LUT entry unchanged (verified by later jump target).
- Restart: in DONE with Start held 1 -> stays DONE; Start=0 -> IDLE; new Start pulse -> RUN from PC 0, InstCnt restarts at 0.
